// File: rtl/wb_shared_arbiter_if.sv
// Bus bundle for wb_shared_arbiter: two Wishbone masters, one shared slave port, status.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_shared_arbiter_if;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o;
  logic [3:0]  s_sel;
  logic        s_ack;
  logic [31:0] s_dat_i, rd_dat;
  logic [1:0]  grant;
  logic [7:0]  timeout_cnt;

  modport slave (
    input  m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_sel,
    input  m1_cyc, m1_stb, m1_we, m1_adr, m1_dat, m1_sel,
    input  s_ack, s_dat_i,
    output m0_ack, m0_err, m1_ack, m1_err,
    output s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel,
    output rd_dat, grant, timeout_cnt
  );

  modport master (
    output m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_sel,
    output m1_cyc, m1_stb, m1_we, m1_adr, m1_dat, m1_sel,
    output s_ack, s_dat_i,
    input  m0_ack, m0_err, m1_ack, m1_err,
    input  s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel,
    input  rd_dat, grant, timeout_cnt
  );
endinterface

// File: rtl/wb_shared_arbiter.sv
// Two-master Wishbone arbiter (CPU=m0, DMA=m1) for the shared memory slave port, with ack timeout.
// Define WB_ARB_ROUND_ROBIN_EN to break simultaneous requests round-robin instead of DMA-first.
module wb_shared_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned HOLD_MAX       = 64
) (
  input logic                  sys_clk,
  input logic                  reset,
  wb_shared_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] err_q, err_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       last_q, last_d;
  logic       handoff_q, handoff_d;

  logic       own_cyc, own_stb, oth_cyc, beat, pick1;
  logic [7:0] hold_inc, wait_inc;

  always_comb begin
    own_cyc  = (state_q == OWN1) ? bus.m1_cyc : bus.m0_cyc;
    own_stb  = (state_q == OWN1) ? bus.m1_stb : bus.m0_stb;
    oth_cyc  = (state_q == OWN1) ? bus.m0_cyc : bus.m1_cyc;
    beat     = bus.s_ack & own_stb;
    hold_inc = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
    wait_inc = wait_q + 8'd1;

`ifdef WB_ARB_ROUND_ROBIN_EN
    pick1 = (bus.m0_cyc && bus.m1_cyc) ? ~last_q : bus.m1_cyc;
`else
    pick1 = bus.m1_cyc;
`endif
    // After a forced release the waiting master gets the bus regardless of tie-break policy
    if (handoff_q && (last_q ? bus.m0_cyc : bus.m1_cyc))
      pick1 = ~last_q;

    state_d   = state_q;
    grant_d   = grant_q;
    err_d     = '0;
    wait_d    = wait_q;
    hold_d    = hold_q;
    tcnt_d    = tcnt_q;
    last_d    = last_q;
    handoff_d = handoff_q;

    case (state_q)
      IDLE: begin
        wait_d    = '0;
        hold_d    = '0;
        handoff_d = 1'b0;
        if (bus.m0_cyc || bus.m1_cyc) begin
          state_d = pick1 ? OWN1 : OWN0;
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
        end
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          wait_d  = '0;
        end else if (beat) begin
          wait_d = '0;
          hold_d = hold_inc;
          if (32'(hold_inc) >= HOLD_MAX && oth_cyc) begin
            state_d   = IDLE;
            grant_d   = '0;
            handoff_d = 1'b1;
          end
        end else if (own_stb) begin
          wait_d = wait_inc;
          if (32'(wait_inc) >= TIMEOUT_CYCLES) begin
            state_d = ABORT;
            grant_d = '0;
            wait_d  = '0;
            err_d   = (state_q == OWN1) ? 2'b10 : 2'b01;
            tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
          end
        end else begin
          wait_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      err_q     <= '0;
      wait_q    <= '0;
      hold_q    <= '0;
      tcnt_q    <= '0;
      last_q    <= 1'b0;
      handoff_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      hold_q    <= hold_d;
      tcnt_q    <= tcnt_d;
      last_q    <= last_d;
      handoff_q <= handoff_d;
    end
  end

  logic        s_cyc_c, s_stb_c, s_we_c, m0_ack_c, m1_ack_c;
  logic [31:0] s_adr_c, s_dat_c;
  logic [3:0]  s_sel_c;

  always_comb begin
    s_cyc_c  = 1'b0;
    s_stb_c  = 1'b0;
    s_we_c   = 1'b0;
    s_adr_c  = '0;
    s_dat_c  = '0;
    s_sel_c  = '0;
    m0_ack_c = 1'b0;
    m1_ack_c = 1'b0;
    case (state_q)
      OWN0: begin
        s_cyc_c  = bus.m0_cyc;
        s_stb_c  = bus.m0_stb;
        s_we_c   = bus.m0_we;
        s_adr_c  = bus.m0_adr;
        s_dat_c  = bus.m0_dat;
        s_sel_c  = bus.m0_sel;
        m0_ack_c = bus.s_ack & bus.m0_stb;
      end
      OWN1: begin
        s_cyc_c  = bus.m1_cyc;
        s_stb_c  = bus.m1_stb;
        s_we_c   = bus.m1_we;
        s_adr_c  = bus.m1_adr;
        s_dat_c  = bus.m1_dat;
        s_sel_c  = bus.m1_sel;
        m1_ack_c = bus.s_ack & bus.m1_stb;
      end
      default: ;
    endcase
  end

  assign bus.s_cyc       = s_cyc_c;
  assign bus.s_stb       = s_stb_c;
  assign bus.s_we        = s_we_c;
  assign bus.s_adr       = s_adr_c;
  assign bus.s_dat_o     = s_dat_c;
  assign bus.s_sel       = s_sel_c;
  assign bus.m0_ack      = m0_ack_c;
  assign bus.m1_ack      = m1_ack_c;
  assign bus.m0_err      = err_q[0];
  assign bus.m1_err      = err_q[1];
  assign bus.rd_dat      = bus.s_dat_i;
  assign bus.grant       = grant_q;
  assign bus.timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_wb_shared_arbiter.sv
// Directed bench for wb_shared_arbiter with TIMEOUT_CYCLES=8, HOLD_MAX=4.
module tb_wb_shared_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  wb_shared_arbiter_if bus ();

  wb_shared_arbiter #(.TIMEOUT_CYCLES(8), .HOLD_MAX(4)) dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int unsigned acks;
    int unsigned guard;
    logic [1:0] tie_exp;

    bus.m0_cyc = 0; bus.m0_stb = 0; bus.m0_we = 0; bus.m0_adr = '0; bus.m0_dat = '0; bus.m0_sel = '0;
    bus.m1_cyc = 0; bus.m1_stb = 0; bus.m1_we = 0; bus.m1_adr = '0; bus.m1_dat = '0; bus.m1_sel = '0;
    bus.s_ack = 0; bus.s_dat_i = '0;

    #12;
    check_val("rst_grant", 32'(bus.grant), 32'h0);
    check_val("rst_scyc", 32'(bus.s_cyc), 32'h0);
    check_val("rst_tcnt", 32'(bus.timeout_cnt), 32'h0);
    check_val("rst_err", 32'({bus.m1_err, bus.m0_err}), 32'h0);
    step();
    rst = 1'b0;

    // single CPU read
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m0_adr = 32'h0000_0100; bus.m0_sel = 4'hF;
    #1;
    check_val("c0_idle_grant", 32'(bus.grant), 32'h0);
    check_val("c0_idle_scyc", 32'(bus.s_cyc), 32'h0);
    step();
    check_val("c1_grant", 32'(bus.grant), 32'h1);
    check_val("c1_sadr", bus.s_adr, 32'h0000_0100);
    check_val("c1_scyc", 32'(bus.s_cyc), 32'h1);
    step();
    step();
    bus.s_ack = 1; bus.s_dat_i = 32'hE59F_F018;
    #1;
    check_val("c3_m0ack", 32'(bus.m0_ack), 32'h1);
    check_val("c3_rddat", bus.rd_dat, 32'hE59F_F018);
    check_val("c3_m1ack", 32'(bus.m1_ack), 32'h0);
    step();
    bus.s_ack = 0; bus.m0_cyc = 0; bus.m0_stb = 0;
    step();
    check_val("rel_idle", 32'(bus.grant), 32'h0);

    // simultaneous request: DMA first, one bubble, then CPU
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m0_adr = 32'h0000_0200;
    bus.m1_cyc = 1; bus.m1_stb = 1; bus.m1_we = 1; bus.m1_adr = 32'h0000_0300;
    bus.m1_dat = 32'hA5A5_0001; bus.m1_sel = 4'h3;
    step();
    check_val("tie_grant", 32'(bus.grant), 32'h2);
    check_val("tie_sadr", bus.s_adr, 32'h0000_0300);
    check_val("tie_sdat", bus.s_dat_o, 32'hA5A5_0001);
    check_val("tie_ssel", 32'(bus.s_sel), 32'h3);
    check_val("tie_swe", 32'(bus.s_we), 32'h1);
    bus.s_ack = 1;
    #1;
    check_val("tie_m1ack", 32'(bus.m1_ack), 32'h1);
    check_val("tie_m0ack", 32'(bus.m0_ack), 32'h0);
    step();
    bus.s_ack = 0; bus.m1_cyc = 0; bus.m1_stb = 0; bus.m1_we = 0;
    #1;
    check_val("drop_scyc", 32'(bus.s_cyc), 32'h0);
    step();
    check_val("bubble_grant", 32'(bus.grant), 32'h0);
    step();
    check_val("cpu_grant", 32'(bus.grant), 32'h1);
    check_val("cpu_sadr", bus.s_adr, 32'h0000_0200);
    bus.m0_cyc = 0; bus.m0_stb = 0;
    step();
    step();

    // DMA alone so that last_owner = 1, then a tie
    bus.m1_cyc = 1; bus.m1_stb = 1;
    step();
    bus.m1_cyc = 0; bus.m1_stb = 0;
    step();
    step();
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m1_cyc = 1; bus.m1_stb = 1;
    step();
`ifdef WB_ARB_ROUND_ROBIN_EN
    tie_exp = 2'b01;
`else
    tie_exp = 2'b10;
`endif
    check_val("tie2_grant", 32'(bus.grant), 32'(tie_exp));
    bus.m0_cyc = 0; bus.m0_stb = 0; bus.m1_cyc = 0; bus.m1_stb = 0;
    step();
    step();

    // hold limit: DMA bursting, CPU waiting
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m1_cyc = 1; bus.m1_stb = 1;
    step();
    check_val("hold_grant", 32'(bus.grant), 32'h2);
    bus.s_ack = 1;
    #1;
    acks = 0;
    guard = 0;
    while (bus.grant == 2'b10 && guard < 20) begin
      if (bus.m1_ack) acks++;
      step();
      guard++;
    end
    check_val("hold_acks", acks, 32'd4);
    check_val("hold_idle", 32'(bus.grant), 32'h0);
    check_val("idle_ack_ign", 32'({bus.m1_ack, bus.m0_ack}), 32'h0);
    step();
    check_val("handoff_grant", 32'(bus.grant), 32'h1);
    check_val("handoff_m0ack", 32'(bus.m0_ack), 32'h1);
    bus.s_ack = 0; bus.m0_cyc = 0; bus.m0_stb = 0;
    step();
    step();
    check_val("back_to_dma", 32'(bus.grant), 32'h2);
    bus.m1_cyc = 0; bus.m1_stb = 0;
    step();
    step();

    // timeout: 8 stalled cycles then ABORT
    bus.m0_cyc = 1; bus.m0_stb = 1;
    step();
    repeat (7) step();
    check_val("to_pre_err", 32'(bus.m0_err), 32'h0);
    check_val("to_pre_scyc", 32'(bus.s_cyc), 32'h1);
    step();
    check_val("abort_err", 32'(bus.m0_err), 32'h1);
    check_val("abort_m1err", 32'(bus.m1_err), 32'h0);
    check_val("abort_scyc", 32'(bus.s_cyc), 32'h0);
    check_val("abort_tcnt", 32'(bus.timeout_cnt), 32'h1);
    bus.m0_cyc = 0; bus.m0_stb = 0;
    step();
    check_val("post_abort_err", 32'(bus.m0_err), 32'h0);
    check_val("post_abort_grant", 32'(bus.grant), 32'h0);

    // ack on the threshold cycle wins
    bus.m0_cyc = 1; bus.m0_stb = 1;
    step();
    repeat (7) step();
    bus.s_ack = 1;
    #1;
    check_val("thr_ack", 32'(bus.m0_ack), 32'h1);
    check_val("thr_noerr", 32'(bus.m0_err), 32'h0);
    step();
    bus.s_ack = 0;
    #1;
    check_val("thr_err_after", 32'(bus.m0_err), 32'h0);
    check_val("thr_grant", 32'(bus.grant), 32'h1);
    check_val("thr_tcnt", 32'(bus.timeout_cnt), 32'h1);
    bus.m0_cyc = 0; bus.m0_stb = 0;
    step();
    step();

    // asynchronous reset during OWN1
    bus.m1_cyc = 1; bus.m1_stb = 1;
    step();
    check_val("pre_rst_grant", 32'(bus.grant), 32'h2);
    bus.s_ack = 1;
    #1;
    rst = 1'b1;
    #1;
    check_val("arst_scyc", 32'(bus.s_cyc), 32'h0);
    check_val("arst_grant", 32'(bus.grant), 32'h0);
    check_val("arst_ack", 32'({bus.m1_ack, bus.m0_ack}), 32'h0);
    check_val("arst_err", 32'({bus.m1_err, bus.m0_err}), 32'h0);
    check_val("arst_tcnt", 32'(bus.timeout_cnt), 32'h0);
    bus.s_ack = 0;
    step();
    rst = 1'b0;
    #1;
    check_val("rel_idle_grant", 32'(bus.grant), 32'h0);
    step();
    check_val("rel_grant", 32'(bus.grant), 32'h2);
    bus.m1_cyc = 0; bus.m1_stb = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_shared_arbiter.md
Name: wb_shared_arbiter

Overview:
- Two-master Wishbone arbiter for the shared external memory slave port (BIOS/DRAM/VRAM/NVRAM path behind the C-model data input).
- Master 0 is the ZAP CPU. Master 1 is the MADAM DMA/CEL engine.
- Sequences ownership of the single slave port and routes ack/data to the owner only.
- Aborts stalled cycles with a per-transfer ack timeout and an error pulse.

Parameters:
- TIMEOUT_CYCLES, 255, cycles with s_stb high and no s_ack before abort; legal range 1..255; counter is 8 bits.
- HOLD_MAX, 64, max consecutive acked beats a master may hold the bus while the other master requests; legal range 1..255; counter is 8 bits.

Ports:
- sys_clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  CPU bus request
- m0_adr  in  32  CPU address
- m0_dat  in  32  CPU write data
- m0_sel  in  4  CPU byte select
- m0_ack  out  1  ack to CPU
- m0_err  out  1  timeout error to CPU
- m1_cyc, m1_stb, m1_we  in  1 each  DMA bus request
- m1_adr  in  32  DMA address
- m1_dat  in  32  DMA write data
- m1_sel  in  4  DMA byte select
- m1_ack  out  1  ack to DMA
- m1_err  out  1  timeout error to DMA
- s_cyc, s_stb, s_we  out  1 each  slave bus
- s_adr  out  32  slave address
- s_dat_o  out  32  slave write data
- s_sel  out  4  slave byte select
- s_ack  in  1  slave ack
- rd_dat  out  32  s_dat_i passed through to both masters, unregistered
- s_dat_i  in  32  slave read data
- grant  out  2  one-hot current owner; 00 = none
- timeout_cnt  out  8  total aborts, saturating at 255

Behaviour:
- Reset (async, active-high):
  - state=IDLE, grant=00, all s_* outputs 0, m*_ack=0, m*_err=0.
  - Both counters=0, timeout_cnt=0, last_owner=0.
- States: IDLE, OWN0, OWN1, ABORT.
- IDLE:
  - m1_cyc → OWN1 next cycle; else m0_cyc → OWN0; else stay.
  - A request sampled in cycle N gets grant in cycle N+1. s_cyc=0 throughout IDLE.
- OWNx:
  - s_cyc/s_stb/s_we/s_adr/s_dat_o/s_sel combinationally muxed from master x.
  - mx_ack = s_ack & s_stb; the other master's ack is forced 0.
- Release:
  - Owner's cyc deasserts → IDLE next cycle. The one-cycle bubble is mandatory.
  - Forced release: hold counter counts acked beats. When it reaches HOLD_MAX while the other master has cyc high, the owner is released after the current acked beat → IDLE, and the other master is then granted.
  - The hold counter clears on entering IDLE.
- Timeout:
  - Wait counter increments each OWNx cycle with s_stb=1 and s_ack=0. It clears on s_ack or when stb drops.
  - When it reaches TIMEOUT_CYCLES → ABORT.
- ABORT (exactly 1 cycle):
  - s_cyc=s_stb=0; mx_err=1 for the owner; timeout_cnt+1 (saturating).
  - Then → IDLE. The master must drop cyc; if it still requests it re-arbitrates normally.
- s_ack arriving in the same cycle as the timeout threshold: the ack wins, no abort.
- s_ack while in IDLE or ABORT is ignored and not forwarded.
- m*_err is asserted only in ABORT; never together with ack.
- last_owner updates on each entry to OWN0/OWN1.

Optional Feature:
- Macro: WB_ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both cyc high, grant goes to the master that is not last_owner. Single requester is granted directly.
- Undefined: fixed priority, m1 (DMA) always wins ties; last_owner is still tracked but unused for arbitration.

Test Plan:
- Single CPU read: m0_cyc/stb at cycle 0, adr=0x00000100, slave acks at cycle 3 with s_dat_i=0xE59FF018 → grant=01 at cycle 1; m0_ack=1 at cycle 3 with rd_dat=0xE59FF018; m1_ack stays 0.
- Simultaneous request, macro undefined: both cyc at cycle 0 → grant=10 at cycle 1. After m1 drops cyc: one IDLE cycle, then grant=01.
- Same stimulus with WB_ARB_ROUND_ROBIN_EN and last_owner=1 → grant=01 first.
- Hold limit: HOLD_MAX=4, DMA bursts with ack every cycle, CPU requesting → after 4th ack: IDLE, then grant=01. DMA sees exactly 4 acks before losing the bus.
- Timeout: TIMEOUT_CYCLES=8, CPU stb held, no s_ack → after 8 wait cycles ABORT: m0_err=1 for 1 cycle, s_cyc=0, timeout_cnt=1.
  - Repeat with s_ack on the threshold cycle → m0_ack=1, no err, timeout_cnt unchanged.
- Reset mid-transfer: assert reset during OWN1 with stb high → same cycle, asynchronously: s_cyc=0, grant=00, acks/errs=0, timeout_cnt=0. After release, the next request takes the normal 1-cycle grant latency.
